// File: rtl/compare_fault_latch.sv
// Debounces window-comparator flags and latches a trip until software clears it.
// Re-arms only once every unmasked raw flag has dropped.
module compare_fault_latch #(
  parameter int CHANNELS     = 4,
  parameter int FILTER_WIDTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [2*CHANNELS-1:0]             compare_i,
  input  logic [2*CHANNELS-1:0]             mask_i,
  input  logic [FILTER_WIDTH-1:0]           filter_limit_i,
  input  logic                              enable_i,
  input  logic                              clear_i,
  output logic                              fault_o,
  output logic [2*CHANNELS-1:0]             fault_flags_o,
  output logic [$clog2(2*CHANNELS)-1:0]     first_fault_o,
  output logic [1:0]                        state_o,
  output logic [7:0]                        trip_count_o
);
  localparam int FLAGS     = 2 * CHANNELS;
  localparam int IDX_WIDTH = $clog2(FLAGS);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    TRIPPED  = 2'b10,
    CLEARING = 2'b11
  } state_t;

  state_t                                state_q, state_d;
  logic [FLAGS-1:0][FILTER_WIDTH-1:0]    cnt_q, cnt_d;
  logic [FILTER_WIDTH-1:0]               lim;
  logic [FLAGS-1:0]                      active;
  logic [FLAGS-1:0]                      trip_vec;
  logic                                  trip;
  logic [IDX_WIDTH-1:0]                  first_idx;
  logic [FLAGS-1:0]                      flags_q;
  logic [IDX_WIDTH-1:0]                  first_q;
  logic [7:0]                            trip_count_q;

  // Filter: >= rather than == so a lowered limit trips a long-running count at once.
  always_comb begin
    lim      = (filter_limit_i == '0) ? FILTER_WIDTH'(1) : filter_limit_i;
    active   = compare_i & ~mask_i;
    trip_vec = '0;
    cnt_d    = '0;
    for (int i = 0; i < FLAGS; i++) begin
      if (state_q == ARMED && active[i]) begin
        trip_vec[i] = (cnt_q[i] >= lim - FILTER_WIDTH'(1));
        cnt_d[i]    = (cnt_q[i] >= lim) ? lim : cnt_q[i] + FILTER_WIDTH'(1);
      end
    end
    trip      = |trip_vec;
    first_idx = '0;
    for (int i = FLAGS - 1; i >= 0; i--) begin
      if (trip_vec[i]) first_idx = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable_i) state_d = ARMED;
      ARMED: begin
        if (trip)           state_d = TRIPPED;
        else if (!enable_i) state_d = IDLE;
      end
      TRIPPED:  if (clear_i) state_d = CLEARING;
      CLEARING: begin
        if (!enable_i)           state_d = IDLE;
        else if (active == '0)   state_d = ARMED;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flags_q      <= '0;
      first_q      <= '0;
      trip_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ARMED && trip) begin
        flags_q <= trip_vec;
        first_q <= first_idx;
        if (trip_count_q != 8'hFF) trip_count_q <= trip_count_q + 8'd1;
      end else if (state_q == CLEARING && state_d != CLEARING) begin
        flags_q <= '0;
        first_q <= '0;
      end
    end
  end

  assign fault_o       = (state_q == TRIPPED) || (state_q == CLEARING);
  assign fault_flags_o = flags_q;
  assign first_fault_o = first_q;
  assign state_o       = state_q;
  assign trip_count_o  = trip_count_q;
endmodule

// File: tb/tb_compare_fault_latch.sv
// Directed bench for compare_fault_latch: driver pushes expected output snapshots,
// a negedge monitor pops and compares them.
module tb_compare_fault_latch;
  localparam int W = 22;  // {fault, flags[7:0], first[2:0], state[1:0], count[7:0]}

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] compare_i = '0;
  logic [7:0] mask_i = '0;
  logic [3:0] filter_limit_i = 4'd3;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       fault_o;
  logic [7:0] fault_flags_o;
  logic [2:0] first_fault_o;
  logic [1:0] state_o;
  logic [7:0] trip_count_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_TRIP = 2'd2, S_CLR = 2'd3;

  compare_fault_latch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .compare_i(compare_i), .mask_i(mask_i),
    .filter_limit_i(filter_limit_i), .enable_i(enable_i), .clear_i(clear_i),
    .fault_o(fault_o), .fault_flags_o(fault_flags_o), .first_fault_o(first_fault_o),
    .state_o(state_o), .trip_count_o(trip_count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(input logic f, input logic [7:0] fl,
                                        input logic [2:0] fi, input logic [1:0] st,
                                        input logic [7:0] cnt);
    return {f, fl, fi, st, cnt};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step(input string nm, input logic [W-1:0] e);
    tick();
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk_i) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fault_o, fault_flags_o, first_fault_o, state_o, trip_count_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got fault=%0b flags=%02h first=%0d state=%0d count=%0d, required fault=%0b flags=%02h first=%0d state=%0d count=%0d",
                 nm, a[21], a[20:13], a[12:10], a[9:8], a[7:0],
                 e[21], e[20:13], e[12:10], e[9:8], e[7:0]);
      end
    end
  end

  initial begin
    repeat (2) tick();
    rst_ni = 1'b1;
    step("reset_state", pack(0, 8'h00, 0, S_IDLE, 0));

    // limit 3: broken burst of 2 does not trip, 3 consecutive do
    filter_limit_i = 4'd3;
    enable_i = 1'b1;
    step("arm", pack(0, 8'h00, 0, S_ARMED, 0));
    compare_i = 8'h01;
    step("burst1_a", pack(0, 8'h00, 0, S_ARMED, 0));
    step("burst1_b", pack(0, 8'h00, 0, S_ARMED, 0));
    compare_i = 8'h00;
    step("gap", pack(0, 8'h00, 0, S_ARMED, 0));
    compare_i = 8'h01;
    step("burst2_a", pack(0, 8'h00, 0, S_ARMED, 0));
    step("burst2_b", pack(0, 8'h00, 0, S_ARMED, 0));
    step("burst2_trip", pack(1, 8'h01, 0, S_TRIP, 1));
    compare_i = 8'h00;
    clear_i = 1'b1;
    step("clear1", pack(1, 8'h01, 0, S_CLR, 1));
    clear_i = 1'b0;
    step("rearm1", pack(0, 8'h00, 0, S_ARMED, 1));

    // limit 0 acts as 1; simultaneous trips on bits 5 and 2
    filter_limit_i = 4'd0;
    compare_i = 8'h24;
    step("dual_trip", pack(1, 8'h24, 2, S_TRIP, 2));
    enable_i = 1'b0;
    compare_i = 8'h04;
    step("enable_ignored_tripped", pack(1, 8'h24, 2, S_TRIP, 2));
    clear_i = 1'b1;
    step("clear2", pack(1, 8'h24, 2, S_CLR, 2));
    clear_i = 1'b0;
    enable_i = 1'b1;
    step("clearing_blocked", pack(1, 8'h24, 2, S_CLR, 2));
    compare_i = 8'h00;
    step("rearm2", pack(0, 8'h00, 0, S_ARMED, 2));

    // masked bit0 held high
    mask_i = 8'h01;
    compare_i = 8'h01;
    step("masked_no_trip", pack(0, 8'h00, 0, S_ARMED, 2));
    clear_i = 1'b1;
    step("clear_in_armed", pack(0, 8'h00, 0, S_ARMED, 2));
    clear_i = 1'b0;
    compare_i = 8'h03;
    step("bit1_trip", pack(1, 8'h02, 1, S_TRIP, 3));
    compare_i = 8'h01;
    clear_i = 1'b1;
    step("clear3", pack(1, 8'h02, 1, S_CLR, 3));
    clear_i = 1'b0;
    step("mask_not_blocking", pack(0, 8'h00, 0, S_ARMED, 3));
    enable_i = 1'b0;
    step("armed_to_idle", pack(0, 8'h00, 0, S_IDLE, 3));
    clear_i = 1'b1;
    step("clear_in_idle", pack(0, 8'h00, 0, S_IDLE, 3));
    clear_i = 1'b0;
    mask_i = 8'h00;
    compare_i = 8'h00;

    // trip beats disable in the same cycle; CLEARING exits to IDLE when disabled
    enable_i = 1'b1;
    step("arm2", pack(0, 8'h00, 0, S_ARMED, 3));
    compare_i = 8'h80;
    enable_i = 1'b0;
    step("trip_wins", pack(1, 8'h80, 7, S_TRIP, 4));
    compare_i = 8'h00;
    clear_i = 1'b1;
    step("clear4", pack(1, 8'h80, 7, S_CLR, 4));
    clear_i = 1'b0;
    step("clearing_to_idle", pack(0, 8'h00, 0, S_IDLE, 4));

    // limit lowered mid-count trips on the next sample
    enable_i = 1'b1;
    step("arm3", pack(0, 8'h00, 0, S_ARMED, 4));
    filter_limit_i = 4'd15;
    compare_i = 8'h10;
    repeat (3) tick();
    filter_limit_i = 4'd2;
    step("limit_lowered", pack(1, 8'h10, 4, S_TRIP, 5));
    compare_i = 8'h00;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    step("rearm4", pack(0, 8'h00, 0, S_ARMED, 5));

    // maximum filter length, no wrap
    filter_limit_i = 4'd15;
    compare_i = 8'h08;
    repeat (13) tick();
    step("max_14th", pack(0, 8'h00, 0, S_ARMED, 5));
    step("max_15th", pack(1, 8'h08, 3, S_TRIP, 6));
    compare_i = 8'h00;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();

    // trip counter saturation
    filter_limit_i = 4'd1;
    for (int n = 0; n < 256; n++) begin
      compare_i = 8'h01;
      tick();
      compare_i = 8'h00;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      tick();
    end
    step("count_saturated", pack(0, 8'h00, 0, S_ARMED, 8'd255));
    compare_i = 8'h40;
    step("count_holds", pack(1, 8'h40, 6, S_TRIP, 8'd255));

    // asynchronous reset while TRIPPED, checked before the next clock edge
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    exp_q.push_back(pack(0, 8'h00, 0, S_IDLE, 0));
    name_q.push_back("async_reset");
    tick();
    rst_ni = 1'b1;
    compare_i = 8'h00;
    enable_i = 1'b0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_i);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
